// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain arbiter: pops up to BURST words per grant from a bank of
// show-ahead FIFOs and forwards them through a registered valid/ready stage.
module fifo_drain_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BURST = 4,
  localparam int unsigned SW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               enable,
  input  logic [N-1:0]       fifo_empty,
  input  logic [N*WIDTH-1:0] fifo_rdata,
  output logic [N-1:0]       fifo_pop,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_src
);

  localparam int unsigned CW = $clog2(BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SW-1:0]    grant;
  logic [SW-1:0]    grant_nxt;
  logic [SW-1:0]    last;
  logic [SW-1:0]    last_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             out_valid_nxt;
  logic [WIDTH-1:0] out_data_nxt;
  logic [SW-1:0]    out_src_nxt;

  logic [WIDTH-1:0] words [N];
  logic [WIDTH-1:0] head;
  logic [SW-1:0]    pick;
  logic             found;
  int unsigned      cand;
  logic             slot_free;
  logic             pop_ok;

  for (genvar g = 0; g < N; g++) begin : g_word
    assign words[g] = fifo_rdata[g*WIDTH +: WIDTH];
  end

  assign head = words[grant];

  // First non-empty FIFO after the most recent grant, wrapping N-1 -> 0.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = (32'(last) + i) % N;
      if (!found && !fifo_empty[SW'(cand)]) begin
        found = 1'b1;
        pick  = SW'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state     <= IDLE;
      grant     <= '0;
      last      <= SW'(N - 1);
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      last      <= last_nxt;
      cnt       <= cnt_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_src   <= out_src_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    last_nxt      = last;
    cnt_nxt       = cnt;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    out_src_nxt   = out_src;
    fifo_pop      = '0;

    slot_free = !out_valid || out_ready;
    pop_ok    = (state == GRANT) && !fifo_empty[grant] && slot_free && (cnt < CW'(BURST));

    if (pop_ok) begin
      fifo_pop[grant] = 1'b1;
      out_data_nxt    = head;
      out_src_nxt     = grant;
      out_valid_nxt   = 1'b1;
      cnt_nxt         = cnt + CW'(1);
    end else if (out_ready) begin
      out_valid_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (enable && found) begin
          grant_nxt = pick;
          last_nxt  = pick;
          cnt_nxt   = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        // Backpressure alone never ends a grant; only burst exhaustion or a drained FIFO.
        if ((pop_ok && (cnt == CW'(BURST - 1))) || fifo_empty[grant]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Directed bench for fifo_drain_arbiter: behavioural show-ahead FIFOs feed two
// instances (BURST=4 and BURST=1); expected values are hand-derived per cycle.
module tb_fifo_drain_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned BURST = 4;
  localparam int unsigned SW    = 2;
  localparam int          DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               resetN;
  logic               enable;
  logic               out_ready;
  logic [N-1:0]       fifo_empty;
  logic [N-1:0]       fifo_pop;
  logic [N*WIDTH-1:0] fifo_rdata;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SW-1:0]      out_src;

  logic               enable_b;
  logic               ready_b;
  logic [N-1:0]       empty_b;
  logic [N-1:0]       pop_b;
  logic [N*WIDTH-1:0] rdata_b;
  logic               valid_b;
  logic [WIDTH-1:0]   data_b;
  logic [SW-1:0]      src_b;

  logic [WIDTH-1:0] mem [N][DEPTH];
  int               rd_ptr [N];
  int               wr_ptr [N];
  logic [WIDTH-1:0] mem_b [DEPTH];
  int               rd_b = 0;
  int               wr_b = 0;

  int passed = 0;
  int total  = 0;

  fifo_drain_arbiter #(.N(N), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk(clk), .resetN(resetN), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_pop(fifo_pop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src)
  );

  fifo_drain_arbiter #(.N(N), .WIDTH(WIDTH), .BURST(1)) dut_b (
    .clk(clk), .resetN(resetN), .enable(enable_b),
    .fifo_empty(empty_b), .fifo_rdata(rdata_b), .fifo_pop(pop_b),
    .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b), .out_src(src_b)
  );

  // Show-ahead FIFO models: empty/head update on the edge that pops.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (fifo_pop[i] && rd_ptr[i] != wr_ptr[i]) rd_ptr[i] <= rd_ptr[i] + 1;
    if (pop_b[3] && rd_b != wr_b) rd_b <= rd_b + 1;
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      fifo_empty[i] = (rd_ptr[i] == wr_ptr[i]);
      fifo_rdata[i*WIDTH +: WIDTH] = mem[i][rd_ptr[i] % DEPTH];
    end
    empty_b = {rd_b == wr_b, 3'b111};
    rdata_b = {mem_b[rd_b % DEPTH], 48'h0};
  end

  function automatic logic [WIDTH-1:0] word(input int f, input int k);
    return 16'(16'h1000 * (f + 1) + k);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic load(input int f, input int n);
    for (int k = 0; k < n; k++) begin
      mem[f][wr_ptr[f] % DEPTH] = word(f, k);
      wr_ptr[f] = wr_ptr[f] + 1;
    end
  endtask

  task automatic do_reset();
    resetN   = 1'b0;
    enable   = 1'b0;
    enable_b = 1'b0;
    for (int i = 0; i < N; i++) wr_ptr[i] = rd_ptr[i];
    wr_b = rd_b;
    next_cycle();
    resetN = 1'b1;
  endtask

  typedef struct {
    logic             en;
    logic             rdy;
    logic [N-1:0]     pop;
    logic             vld;
    logic [SW-1:0]    src;
    logic [WIDTH-1:0] data;
  } vec_t;

  vec_t             tbl [6];
  int               got_src [$];
  logic [WIDTH-1:0] got_data [$];
  int               got_cyc [$];
  logic [WIDTH-1:0] acc [$];
  int               fl [3];
  int               j;
  int               stall_viol;
  int               pops;
  logic [7:0]       epop_b;
  logic [7:0]       evld_b;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetN    = 1'b0;
    enable    = 1'b0;
    out_ready = 1'b1;
    enable_b  = 1'b0;
    ready_b   = 1'b1;
    repeat (2) next_cycle();
    sample();
    check("reset out_valid", 32'(out_valid), 0);
    check("reset out_src", 32'(out_src), 0);
    check("reset out_data", 32'(out_data), 0);
    check("reset fifo_pop", 32'(fifo_pop), 0);
    next_cycle();
    resetN = 1'b1;

    // Single FIFO drain: FIFO 2 holds three words.
    tbl[0] = '{1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0};
    tbl[1] = '{1'b1, 1'b1, 4'b0100, 1'b0, 2'd0, 16'h0};
    tbl[2] = '{1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, word(2, 0)};
    tbl[3] = '{1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, word(2, 1)};
    tbl[4] = '{1'b1, 1'b1, 4'b0000, 1'b1, 2'd2, word(2, 2)};
    tbl[5] = '{1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0};
    do_reset();
    load(2, 3);
    for (int r = 0; r < 6; r++) begin
      enable    = tbl[r].en;
      out_ready = tbl[r].rdy;
      sample();
      check($sformatf("drain[%0d] fifo_pop", r), 32'(fifo_pop), 32'(tbl[r].pop));
      check($sformatf("drain[%0d] out_valid", r), 32'(out_valid), 32'(tbl[r].vld));
      if (tbl[r].vld) begin
        check($sformatf("drain[%0d] out_src", r), 32'(out_src), 32'(tbl[r].src));
        check($sformatf("drain[%0d] out_data", r), 32'(out_data), 32'(tbl[r].data));
      end
      next_cycle();
    end

    // Fairness: three requesters with 8 words each, bursts of 4.
    do_reset();
    load(0, 8);
    load(1, 8);
    load(3, 8);
    enable    = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 120 && got_src.size() < 24; c++) begin
      sample();
      if (out_valid) begin
        got_src.push_back(int'(out_src));
        got_data.push_back(out_data);
        got_cyc.push_back(c);
      end
      next_cycle();
    end
    check("fair word count", got_src.size(), 24);
    fl[0] = 0;
    fl[1] = 1;
    fl[2] = 3;
    j = 0;
    for (int r = 0; r < 2; r++)
      for (int f = 0; f < 3; f++)
        for (int k = 0; k < 4; k++) begin
          if (j < got_src.size()) begin
            check($sformatf("fair[%0d] src", j), got_src[j], fl[f]);
            check($sformatf("fair[%0d] data", j), got_data[j], word(fl[f], r * 4 + k));
            if (j > 0)
              check($sformatf("fair[%0d] gap", j), got_cyc[j] - got_cyc[j-1], (k == 0) ? 2 : 1);
          end
          j++;
        end

    // Backpressure: out_ready cycles 1,0,0,1 while FIFO 0 holds 5 words.
    do_reset();
    load(0, 5);
    enable     = 1'b1;
    stall_viol = 0;
    pops       = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      sample();
      if (fifo_pop != '0 && out_valid && !out_ready) stall_viol++;
      if (fifo_pop[0]) pops++;
      if (out_valid && out_ready) acc.push_back(out_data);
      next_cycle();
    end
    check("bp pop while stalled", stall_viol, 0);
    check("bp pop count", pops, 5);
    check("bp words delivered", acc.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < acc.size()) check($sformatf("bp word[%0d]", k), 32'(acc[k]), 32'(word(0, k)));

    // Reset after the second pop of a FIFO 1 burst; FIFO 3 also requesting.
    do_reset();
    load(1, 4);
    load(3, 2);
    enable    = 1'b1;
    out_ready = 1'b1;
    sample();
    check("rst idle pop", 32'(fifo_pop), 0);
    next_cycle();
    sample();
    check("rst pop1", 32'(fifo_pop), 32'(4'b0010));
    next_cycle();
    sample();
    check("rst pop2", 32'(fifo_pop), 32'(4'b0010));
    check("rst word0", 32'(out_data), 32'(word(1, 0)));
    next_cycle();
    resetN = 1'b0;
    sample();
    check("rst pop during reset", 32'(fifo_pop), 32'(4'b0010));
    next_cycle();
    resetN = 1'b1;
    sample();
    check("rst out_valid cleared", 32'(out_valid), 0);
    check("rst out_src cleared", 32'(out_src), 0);
    check("rst state idle", 32'(fifo_pop), 0);
    next_cycle();
    sample();
    check("rst regrant lowest", 32'(fifo_pop), 32'(4'b0010));
    next_cycle();
    sample();
    check("rst regrant src", 32'(out_src), 1);
    check("rst regrant data", 32'(out_data), 32'(word(1, 3)));
    next_cycle();

    // enable gating with every FIFO non-empty.
    do_reset();
    for (int f = 0; f < N; f++) load(f, 4);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sample();
      check($sformatf("gate[%0d] fifo_pop", c), 32'(fifo_pop), 0);
      check($sformatf("gate[%0d] out_valid", c), 32'(out_valid), 0);
      next_cycle();
    end
    enable = 1'b1;
    sample();
    check("gate arb cycle pop", 32'(fifo_pop), 0);
    next_cycle();
    sample();
    check("gate grant fifo0", 32'(fifo_pop), 32'(4'b0001));
    next_cycle();
    enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample();
      check($sformatf("gate burst pop[%0d]", c + 2), 32'(fifo_pop), 32'(4'b0001));
      next_cycle();
    end
    for (int c = 0; c < 4; c++) begin
      sample();
      check($sformatf("gate after burst[%0d]", c), 32'(fifo_pop), 0);
      next_cycle();
    end

    // BURST=1 instance, FIFO 3 only, three words.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      mem_b[wr_b % DEPTH] = 16'(16'hB000 + k);
      wr_b = wr_b + 1;
    end
    enable_b = 1'b1;
    ready_b  = 1'b1;
    epop_b   = 8'b0010_1010;
    evld_b   = 8'b0101_0100;
    for (int c = 0; c < 8; c++) begin
      sample();
      check($sformatf("b1[%0d] pop", c), 32'(pop_b), 32'({epop_b[c], 3'b000}));
      check($sformatf("b1[%0d] out_valid", c), 32'(valid_b), 32'(evld_b[c]));
      if (evld_b[c]) begin
        check($sformatf("b1[%0d] out_src", c), 32'(src_b), 3);
        check($sformatf("b1[%0d] out_data", c), 32'(data_b), 32'(16'hB000 + (c / 2 - 1)));
      end
      next_cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_drain_arbiter.md
# fifo_drain_arbiter

Round-robin scheduler that drains N show-ahead FIFOs into one valid/ready output stream. It sits on the read side of a bank of FIFOs: it watches their empty flags, drives their pop strobes, and forwards each popped word through a registered output stage tagged with its source index. Each grant is capped at a fixed burst length, so no single requester can monopolise the consumer.

## Interface
- N, 4: number of FIFOs drained, ≥2.
- WIDTH, 16: data word width.
- BURST, 4: maximum pops per grant, ≥1.
- clk  in  1  clock; all logic is on the rising edge.
- resetN  in  1  reset, synchronous, active-low.
- enable  in  1  permits new grants; a burst already in progress always completes.
- fifo_empty  in  N  empty flag of each FIFO; bit i is FIFO i.
- fifo_rdata  in  N*WIDTH  show-ahead head word of each FIFO; FIFO i occupies bits [i*WIDTH +: WIDTH].
- fifo_pop  out  N  combinational, one-hot-or-zero pop strobe to each FIFO.
- out_valid  out  1  out_data and out_src hold a word.
- out_ready  in  1  consumer accepts the word this cycle.
- out_data  out  WIDTH  forwarded word, registered.
- out_src  out  SW  index of the FIFO that supplied out_data, where SW = $clog2(N).

## Operation
- **State machine states:** IDLE and GRANT.
- **Registers:** grant (SW bits), last (SW bits), cnt (width $clog2(BURST+1)), and the output register (out_valid, out_data, out_src).
- **IDLE:**
  - When enable=1 and any fifo_empty bit is 0, pick the first non-empty index scanning last+1, last+2, … modulo N.
  - On that edge: grant←idx, last←idx, cnt←0, state→GRANT.
  - Otherwise stay in IDLE.
  - No pops are issued in IDLE.
- **Output slot:** the slot is free when out_valid=0 or out_ready=1.
- **Pop condition:** pop_ok = (state==GRANT) && !fifo_empty[grant] && slot free && cnt<BURST. fifo_pop[grant]=pop_ok; every other bit is 0.
- **On a pop edge:** out_data←fifo_rdata[grant], out_src←grant, out_valid←1, cnt←cnt+1.
- **On a non-pop edge:** if out_ready=1, out_valid←0. Otherwise out_valid, out_data and out_src hold.
- **GRANT exits to IDLE when either holds:**
  - the edge pops with cnt==BURST-1 (burst exhausted), or
  - fifo_empty[grant]=1 (FIFO drained; empty flag is registered in the FIFO, so this is seen one cycle after the last pop).
- **GRANT does not exit on backpressure.** While the slot is blocked it stays in GRANT with no pop.
- **enable:** sampled only in IDLE. Dropping it mid-burst has no effect until the grant ends.
- **Round robin:** last advances only on a grant. A requester that just finished gets lowest priority in the next arbitration.

## Timing
- **Reset values** (applied on the edge with resetN=0, regardless of state):
  - state=IDLE, last=N-1 (FIFO 0 has first priority), grant=0, cnt=0.
  - out_valid=0, out_data=0, out_src=0.
  - fifo_pop=0 combinationally once state=IDLE.
- **Latency:** fifo_empty[i] falls at cycle t (arbiter IDLE) → grant at edge t+1 → fifo_pop[i]=1 during cycle t+1 → out_valid=1 from edge t+2.
- **Throughput within a burst:** 1 word/cycle while out_ready=1 and the FIFO stays non-empty.
- **Grant overhead:** each grant costs one IDLE bubble cycle. A burst ending on a drained FIFO costs an additional empty-detect cycle.
- **Simultaneous events:**
  - Pop and out_ready in the same cycle: the new word replaces the old one; out_valid stays 1.
  - resetN=0 during a pop cycle: the pop strobe is still driven combinationally in that cycle (the FIFO is assumed to be reset together with the arbiter); the output register clears on the edge.
- **Wrap-around:** the round-robin scan wraps from N-1 to 0. last=N-1 scans 0 first.
- **Data ordering:** within one FIFO, words appear on out_data in pop order. Words are never duplicated or dropped under any out_ready pattern.

## Test plan
- **Single FIFO drain:** N=4, BURST=4. FIFO 2 holds A,B,C; others empty; out_ready=1.
  - Required: pops in 3 consecutive cycles.
  - Required: out_data A,B,C with out_src=2 on consecutive cycles, first word 2 cycles after grant decision.
  - Required: return to IDLE.
- **Fairness:** FIFOs 0,1,3 each hold 8 words; BURST=4; out_ready=1.
  - Required source order: 0×4, 1×4, 3×4, 0×4, 1×4, 3×4.
  - Required: one bubble cycle between bursts.
- **Backpressure:** FIFO 0 holds 5 words; out_ready toggles 1,0,0,1,…
  - Required: no pop while out_valid=1 and out_ready=0.
  - Required: all 5 words delivered exactly once, in order (4 in the first burst, 1 in the next).
- **Reset mid-burst:** assert resetN=0 for 1 cycle after the second pop of a 4-burst from FIFO 1.
  - Required: out_valid=0, out_src=0, state IDLE after the edge.
  - Required: the next grant goes to the lowest-index non-empty FIFO.
- **enable gating:** enable=0 with all FIFOs non-empty.
  - Required: fifo_pop stays 0 and out_valid stays 0.
  - Required: raising enable produces a grant to FIFO 0 on the next edge.
  - Required: dropping enable mid-burst still completes all 4 pops.
- **Burst boundary:** BURST=1, FIFO 3 only, holding 3 words.
  - Required: pop, IDLE, re-grant of 3 (sole requester), repeated.
  - Required: out_valid pattern 1,0,1,0,1 under continuous out_ready.
